// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Multi-cycle integer multiply / divide unit. It sits behind the
//            register file, takes RS/RT read data and produces a 2*WIDTH-bit
//            HI/LO result. The datapath advances one bit per cycle: shift-add
//            for multiply and restoring division for divide.
//            A start/busy/done handshake lets the controller stall the
//            pipeline. A 5-bit destination tag travels with the operation
//            and comes back with the result.
// Optional : MULTDIV_SIGNED_EN - when defined, op[1]=1 selects signed
//            operation (magnitude datapath plus a sign fix at completion).
//            When undefined, op[1] is ignored and every operation is
//            unsigned.
// Ports    : clk      - clock; all state changes on the rising edge
//            rst_n    - synchronous active-low reset
//            start    - begin an operation (sampled when IDLE or DONE)
//            op[1:0]  - op[0]: 0=multiply 1=divide; op[1]: signed
//            rs_data  - multiplicand / dividend
//            rt_data  - multiplier / divisor
//            dest_in  - write-back tag, captured with the operands
//            busy     - high while iterating
//            done     - one-cycle completion pulse
//            hi       - product upper half / remainder
//            lo       - product lower half / quotient
//            dest_out - tag of the completed operation
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6   // must be able to hold the value WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [4:0]       dest_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [4:0]       dest_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Iteration state
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;   // partial product upper half / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier being shifted out / quotient being shifted in
  logic [WIDTH-1:0] opb;      // multiplicand / divisor magnitude
  logic             is_div;
  logic [4:0]       dest_q;

  // Control
  logic accept;
  logic div_zero;
  logic last_iter;

  // Datapath
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] res_hi, res_lo;

  // A zero divisor is resolved at capture time and never enters RUN.
  assign div_zero = op[0] & (rt_data == '0);

  // --------------------------------------------------------------------------
  // Operand conditioning: signed operands are reduced to magnitudes so the
  // iteration datapath is purely unsigned. The most-negative value maps to
  // 2^(WIDTH-1), which is still representable as an unsigned magnitude.
  // --------------------------------------------------------------------------
`ifdef MULTDIV_SIGNED_EN
  logic sgn_op;
  logic rs_neg, rt_neg;
  logic neg_q;    // product / quotient must be negated at completion
  logic neg_r;    // remainder must be negated (follows the dividend's sign)

  assign sgn_op = op[1];
  assign rs_neg = sgn_op & rs_data[WIDTH-1];
  assign rt_neg = sgn_op & rt_data[WIDTH-1];
  assign a_mag  = rs_neg ? (-rs_data) : rs_data;
  assign b_mag  = rt_neg ? (-rt_data) : rt_data;
`else
  logic unused_op_sign;

  assign unused_op_sign = op[1];
  assign a_mag          = rs_data;
  assign b_mag          = rt_data;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake outputs. DONE accepts a new start just like
  // IDLE so operations can be issued back to back without a bubble.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_iter = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start) begin
          accept    = 1'b1;
          state_nxt = div_zero ? S_DONE : S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) begin
          last_iter = 1'b1;
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // One iteration step.
  // Multiply: conditionally add the multiplicand into the upper half, then
  //           shift {carry, acc_hi, acc_lo} right by one. After WIDTH steps
  //           {acc_hi, acc_lo} is the full product.
  // Divide:   shift the next dividend bit into the partial remainder, trial
  //           subtract the divisor and keep the difference only when it did
  //           not borrow. The quotient bit is the inverted borrow.
  // --------------------------------------------------------------------------
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    if (is_div) begin
      step_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // --------------------------------------------------------------------------
  // Result sign fix, applied to the final step as it is written to HI/LO.
  // --------------------------------------------------------------------------
`ifdef MULTDIV_SIGNED_EN
  always_comb begin
    res_hi = step_hi;
    res_lo = step_lo;
    if (is_div) begin
      if (neg_q) begin
        res_lo = -step_lo;
      end
      if (neg_r) begin
        res_hi = -step_hi;
      end
    end else if (neg_q) begin
      {res_hi, res_lo} = -{step_hi, step_lo};
    end
  end
`else
  assign res_hi = step_hi;
  assign res_lo = step_lo;
`endif

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      is_div   <= 1'b0;
      dest_q   <= '0;
      hi       <= '0;
      lo       <= '0;
      dest_out <= '0;
`ifdef MULTDIV_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else if (accept) begin
      cnt    <= CNT_W'(WIDTH);
      acc_hi <= '0;
      acc_lo <= a_mag;
      opb    <= b_mag;
      is_div <= op[0];
      dest_q <= dest_in;
`ifdef MULTDIV_SIGNED_EN
      neg_q  <= rs_neg ^ rt_neg;
      neg_r  <= rs_neg;
`endif
      // Divide by zero completes on the next cycle with a fixed result:
      // the raw dividend in HI and all ones in LO.
      if (div_zero) begin
        hi       <= rs_data;
        lo       <= '1;
        dest_out <= dest_in;
      end
    end else if (state == S_RUN) begin
      cnt    <= cnt - CNT_W'(1);
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      if (last_iter) begin
        hi       <= res_hi;
        lo       <= res_lo;
        dest_out <= dest_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Self-checking bench for mult_div_unit. Expected HI/LO/tag and
//            the completion cycle are pushed to a scoreboard queue when an
//            operation is issued and compared when done pulses.
//            Signed cases follow MULTDIV_SIGNED_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH;   // start edge to the edge that raises done
`ifdef MULTDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [4:0]       dest_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [4:0]       dest_out;

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [4:0]       dest;
    int               due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  mult_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dest_in  (dest_in),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .dest_out (dest_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference model, written directly from the arithmetic definition.
  function automatic exp_t model(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic [4:0] d);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb_, q, r;
    bit          sgn;
    sgn    = SIGNED_EN && o[1];
    e.dest = d;
    e.due  = 0;
    if (!o[0]) begin
      if (sgn) begin
        sa = $signed(a);
        sb_ = $signed(b);
        p  = sa * sb_;
      end else begin
        p = {32'b0, a} * {32'b0, b};
      end
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 0) begin
      e.hi = a;
      e.lo = '1;
    end else if (sgn) begin
      sa = $signed(a);
      sb_ = $signed(b);
      q  = sa / sb_;
      r  = sa % sb_;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Called at posedge+1; start is sampled on the following edge.
  task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [4:0] d);
    exp_t e;
    e       = model(o, a, b, d);
    op      = o;
    rs_data = a;
    rt_data = b;
    dest_in = d;
    start   = 1'b1;
    @(posedge clk);
    #1;
    e.due = cyc + ((o[0] && b == 0) ? 0 : LAT);
    sb.push_back(e);
    start   = 1'b0;
    // Operands are don't-care after capture.
    op      = 2'($urandom_range(0, 3));
    rs_data = $urandom;
    rt_data = $urandom;
    dest_in = 5'($urandom_range(0, 31));
  endtask

  // Bounded wait for done; counts busy cycles seen on the way.
  task automatic wait_done(output int nbusy);
    bit found;
    found = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      if (busy) nbusy++;
      @(posedge clk);
      #1;
    end
    if (!found) check("done_timeout", 64'd0, 64'd1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      check("busy_with_done", {63'b0, busy}, 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("hi", {32'b0, hi}, {32'b0, mon_e.hi});
        check("lo", {32'b0, lo}, {32'b0, mon_e.lo});
        check("dest_out", {59'b0, dest_out}, {59'b0, mon_e.dest});
        check("latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    rst_n   = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    rs_data = '0;
    rt_data = '0;
    dest_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    check("rst_dest", {59'b0, dest_out}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned multiply, busy for exactly WIDTH cycles
    issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5);
    wait_done(nb);
    check("mul_busy_cycles", 64'(nb), 64'(WIDTH));

    // Divide with an ignored start pulse mid-run
    @(posedge clk);
    #1;
    issue(2'b01, 32'd100, 32'd7, 5'd9);
    repeat (5) @(posedge clk);
    #1;
    op = 2'b01; rs_data = 32'd1; rt_data = 32'd1; dest_in = 5'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(nb);
    repeat (3) @(posedge clk);
    #1;
    check("hold_hi", {32'b0, hi}, 64'd2);
    check("hold_lo", {32'b0, lo}, 64'd14);
    check("hold_done", {63'b0, done}, 64'd0);

    // Divide by zero: done next cycle, busy never asserted
    issue(2'b01, 32'h1234_5678, 32'h0, 5'd3);
    wait_done(nb);
    check("dz_busy_cycles", 64'(nb), 64'd0);

    // Back-to-back: second start issued during the done cycle
    @(posedge clk);
    #1;
    issue(2'b00, 32'd7, 32'd6, 5'd10);
    wait_done(nb);
    issue(2'b00, 32'd3, 32'd4, 5'd11);
    wait_done(nb);
    check("b2b_busy_cycles", 64'(nb), 64'(WIDTH));

    // Boundary and random unsigned operations, issued back to back
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12);
    wait_done(nb);
    issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 5'd13);
    wait_done(nb);
    issue(2'b01, 32'h0000_0005, 32'hFFFF_FFFF, 5'd14);
    wait_done(nb);
    issue(2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd15);
    wait_done(nb);
    for (int i = 0; i < 6; i++) begin
      issue({1'b0, 1'(i)}, $urandom, 32'($urandom_range(1, 32'h7FFF_FFFF)) >> (i * 4),
            5'(16 + i));
      wait_done(nb);
    end

    // Signed cases (unsigned results when the signed feature is absent)
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd22);          // -7 / 2
    wait_done(nb);
    issue(2'b10, 32'hFFFF_FFFD, 32'd5, 5'd23);          // -3 * 5
    wait_done(nb);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd24);  // -2^31 / -1
    wait_done(nb);
    issue(2'b10, 32'h8000_0000, 32'h8000_0000, 5'd25);
    wait_done(nb);
    issue(2'b11, 32'd7, 32'hFFFF_FFFE, 5'd26);          // 7 / -2
    wait_done(nb);
    issue(2'b11, 32'hFFFF_FFF0, 32'h0, 5'd27);          // signed divide by zero
    wait_done(nb);

    // Reset mid-run: abort with no done pulse
    @(posedge clk);
    #1;
    issue(2'b00, 32'hFFFF_FFFF, 32'd3, 5'd7);
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_busy", {63'b0, busy}, 64'd1);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_done", {63'b0, done}, 64'd0);
    check("midrst_hi", {32'b0, hi}, 64'd0);
    check("midrst_lo", {32'b0, lo}, 64'd0);
    check("midrst_dest", {59'b0, dest_out}, 64'd0);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_busy", {63'b0, busy}, 64'd0);
    check("post_rst_hi", {32'b0, hi}, 64'd0);

    // One operation after the abort to confirm recovery
    issue(2'b01, 32'd1000, 32'd33, 5'd30);
    wait_done(nb);
    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
